// File: rtl/video_pkg.sv
// video_pkg: shared constants and helpers for the video output stage.
//   BAYER4 / BAYER2  : ordered-dither threshold tables, indexed [y][x].
//   dither_mode_e    : dither algorithm selector (DITHER_MODE parameter value).
//   scale_threshold  : scales a 0..15 Bayer threshold to the number of bits
//                      being dropped, so that the scaled value is always
//                      below 2^drop.
package video_pkg;

  typedef enum logic [1:0] {
    DM_TRUNC    = 2'd0,  // plain truncation
    DM_ORD2     = 2'd1,  // ordered 2x2
    DM_ORD4     = 2'd2,  // ordered 4x4
    DM_TEMPORAL = 2'd3   // ordered 4x4 with per-frame rotation
  } dither_mode_e;

  localparam logic [3:0] BAYER4 [4][4] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6 },
    '{4'd3,  4'd11, 4'd1,  4'd9 },
    '{4'd15, 4'd7,  4'd13, 4'd5 }
  };

  localparam logic [1:0] BAYER2 [2][2] = '{
    '{2'd0, 2'd2},
    '{2'd3, 2'd1}
  };

  // t is a 4-bit threshold (0..15); the result lines its MSB up with the
  // highest dropped bit. Valid for drop up to 31 bits.
  function automatic logic [31:0] scale_threshold(input logic [3:0] t, input int drop);
    if (drop >= 4) return {28'd0, t} << (drop - 4);
    else           return {28'd0, t} >> (4 - drop);
  endfunction

endpackage

// File: rtl/dither_channel.sv
// dither_channel: one colour channel of the dithering pipeline.
//   Stage 1 adds the (already scaled) threshold to the pixel with
//   saturation and keeps only the surviving top OUT_BITS bits.
//   Stage 2 blanks the result outside the active window.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   dither_act   1 = add ts to this pixel, 0 = plain truncation
//   ts           scaled threshold, IN_BITS+1 wide
//   in_pix       input colour value
//   win_s1       window qualifier aligned with the stage-1 register
//   out_pix      registered output colour (2 clk after in_pix)
module dither_channel
  import video_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dither_act,
  input  logic [IN_BITS:0]    ts,
  input  logic [IN_BITS-1:0]  in_pix,
  input  logic                win_s1,
  output logic [OUT_BITS-1:0] out_pix
);

  localparam int DROP = IN_BITS - OUT_BITS;

  logic [IN_BITS:0]    sum;
  logic [OUT_BITS-1:0] hi_d, hi_q;
  logic [OUT_BITS-1:0] out_d, out_q;

  always_comb begin
    // One extra bit catches the carry; a carry means the true sum exceeded
    // full scale, so clamp to all-ones instead of wrapping to black.
    sum   = {1'b0, in_pix} + (dither_act ? ts : '0);
    hi_d  = sum[IN_BITS] ? '1 : OUT_BITS'(sum >> DROP);
    out_d = win_s1 ? hi_q : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q  <= '0;
      out_q <= '0;
    end else begin
      hi_q  <= hi_d;
      out_q <= out_d;
    end
  end

  assign out_pix = out_q;

endmodule

// File: rtl/video_dither_out.sv
// video_dither_out: video output stage between the core video port and the
// board DAC pins. Reduces IN_BITS-per-channel RGB to OUT_BITS using ordered
// dithering (optionally frame-rotated), blanks outside the active window and
// re-polarises the syncs. Every output is registered with 2 clk latency.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   dither_en                       0 forces plain truncation
//   in_red/in_green/in_blue         IN_BITS colour inputs
//   in_hsync/in_vsync               syncs, active level HS_IN_POL/VS_IN_POL
//   in_window                       active-video qualifier
//   out_red/out_green/out_blue      OUT_BITS dithered colour
//   out_hsync/out_vsync             syncs, active level HS_OUT_POL/VS_OUT_POL
//   out_de                          in_window delayed 2 clk
module video_dither_out
  import video_pkg::*;
#(
  parameter int IN_BITS     = 8,
  parameter int OUT_BITS    = 3,
  parameter int DITHER_MODE = 2,
  parameter bit HS_IN_POL   = 1'b0,
  parameter bit VS_IN_POL   = 1'b0,
  parameter bit HS_OUT_POL  = 1'b0,
  parameter bit VS_OUT_POL  = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dither_en,
  input  logic [IN_BITS-1:0]  in_red,
  input  logic [IN_BITS-1:0]  in_green,
  input  logic [IN_BITS-1:0]  in_blue,
  input  logic                in_hsync,
  input  logic                in_vsync,
  input  logic                in_window,
  output logic [OUT_BITS-1:0] out_red,
  output logic [OUT_BITS-1:0] out_green,
  output logic [OUT_BITS-1:0] out_blue,
  output logic                out_hsync,
  output logic                out_vsync,
  output logic                out_de
);

  localparam int           DROP = IN_BITS - OUT_BITS;
  localparam dither_mode_e MODE = dither_mode_e'(DITHER_MODE[1:0]);

  // Sync activity flags and their one-cycle delayed copies for edge detect.
  logic hs_act, vs_act, hs_edge, vs_edge;
  logic hs_prev_d, hs_prev_q, vs_prev_d, vs_prev_q;

  // Screen position within the 4x4 dither cell, and frame phase.
  logic [1:0] x_d, x_q, y_d, y_q, frame_d, frame_q;

  // Sync/window pipe: stage 1 carries active flags, stage 2 output levels.
  logic hs_s1_d, hs_s1_q, vs_s1_d, vs_s1_q, win_s1_d, win_s1_q;
  logic hs_out_d, hs_out_q, vs_out_d, vs_out_q, win_s2_d, win_s2_q;

  logic [1:0]       xi, yi;
  logic [3:0]       t;
  logic [IN_BITS:0] ts;
  logic             dither_act;

  always_comb begin
    hs_act  = (in_hsync == HS_IN_POL);
    vs_act  = (in_vsync == VS_IN_POL);
    hs_edge = hs_act & ~hs_prev_q;
    vs_edge = vs_act & ~vs_prev_q;

    hs_prev_d = hs_act;
    vs_prev_d = vs_act;

    x_d = x_q;
    if (hs_edge)        x_d = 2'd0;
    else if (in_window) x_d = x_q + 2'd1;

    // A vsync edge outranks a coincident hsync edge so each frame starts at row 0.
    y_d = y_q;
    if (vs_edge)      y_d = 2'd0;
    else if (hs_edge) y_d = y_q + 2'd1;

    frame_d = vs_edge ? frame_q + 2'd1 : frame_q;

    hs_s1_d  = hs_act;
    vs_s1_d  = vs_act;
    win_s1_d = in_window;
    hs_out_d = hs_s1_q ? HS_OUT_POL : ~HS_OUT_POL;
    vs_out_d = vs_s1_q ? VS_OUT_POL : ~VS_OUT_POL;
    win_s2_d = win_s1_q;
  end

  // Threshold for the pixel currently entering stage 1. The temporal mode
  // slides the 4x4 cell by one column per frame and one row every two
  // frames, so the pattern at any pixel cycles over four frames.
  always_comb begin
    xi = x_q + ((MODE == DM_TEMPORAL) ? frame_q : 2'd0);
    yi = y_q + ((MODE == DM_TEMPORAL) ? {1'b0, frame_q[1]} : 2'd0);
    case (MODE)
      DM_ORD2:     t = {BAYER2[y_q[0]][x_q[0]], 2'b00};
      DM_ORD4:     t = BAYER4[yi][xi];
      DM_TEMPORAL: t = BAYER4[yi][xi];
      default:     t = 4'd0;
    endcase
    ts         = (IN_BITS+1)'(scale_threshold(t, DROP));
    dither_act = dither_en && (MODE != DM_TRUNC) && (DROP != 0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      x_q       <= 2'd0;
      y_q       <= 2'd0;
      frame_q   <= 2'd0;
      hs_s1_q   <= 1'b0;
      vs_s1_q   <= 1'b0;
      win_s1_q  <= 1'b0;
      hs_out_q  <= ~HS_OUT_POL;
      vs_out_q  <= ~VS_OUT_POL;
      win_s2_q  <= 1'b0;
    end else begin
      hs_prev_q <= hs_prev_d;
      vs_prev_q <= vs_prev_d;
      x_q       <= x_d;
      y_q       <= y_d;
      frame_q   <= frame_d;
      hs_s1_q   <= hs_s1_d;
      vs_s1_q   <= vs_s1_d;
      win_s1_q  <= win_s1_d;
      hs_out_q  <= hs_out_d;
      vs_out_q  <= vs_out_d;
      win_s2_q  <= win_s2_d;
    end
  end

  dither_channel #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_red (
    .clk(clk), .reset(reset), .dither_act(dither_act), .ts(ts),
    .in_pix(in_red), .win_s1(win_s1_q), .out_pix(out_red)
  );

  dither_channel #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_green (
    .clk(clk), .reset(reset), .dither_act(dither_act), .ts(ts),
    .in_pix(in_green), .win_s1(win_s1_q), .out_pix(out_green)
  );

  dither_channel #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_blue (
    .clk(clk), .reset(reset), .dither_act(dither_act), .ts(ts),
    .in_pix(in_blue), .win_s1(win_s1_q), .out_pix(out_blue)
  );

  assign out_hsync = hs_out_q;
  assign out_vsync = vs_out_q;
  assign out_de    = win_s2_q;

endmodule

// File: tb/tb_video_dither_out.sv
// Bench for video_dither_out. Two instances share the inputs: dut runs
// ordered 4x4 (mode 2) with an inverted hsync output; dut_t runs the
// frame-rotated mode 3. Inputs change on the falling edge, outputs are
// compared on the falling edge two cycles after the pixel was applied.
module tb_video_dither_out;

  // Pixels with BAYER4 threshold >= 8; bit index = y*4 + x. For a 0x10 input
  // with 5 dropped bits, ts = t<<1 and 16 + ts reaches 32 exactly when t >= 8.
  localparam logic [15:0] PAT = 16'h5A5A;

  logic       clk = 1'b0;
  logic       reset;
  logic       dither_en;
  logic [7:0] in_red, in_green, in_blue;
  logic       in_hsync, in_vsync, in_window;
  logic [2:0] out_red, out_green, out_blue;
  logic       out_hsync, out_vsync, out_de;
  logic [2:0] t_red, t_green, t_blue;
  logic       t_hsync, t_vsync, t_de;

  logic [15:0] exp_q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  string       phase   = "init";
  logic [1:0]  f_cnt   = 2'd0;

  // ---------------- clock / reset
  always #5 clk = ~clk;

  video_dither_out #(
    .IN_BITS(8), .OUT_BITS(3), .DITHER_MODE(2),
    .HS_IN_POL(1'b0), .VS_IN_POL(1'b0), .HS_OUT_POL(1'b1), .VS_OUT_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .dither_en(dither_en),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_window(in_window),
    .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .out_de(out_de)
  );

  video_dither_out #(
    .IN_BITS(8), .OUT_BITS(3), .DITHER_MODE(3),
    .HS_IN_POL(1'b0), .VS_IN_POL(1'b0), .HS_OUT_POL(1'b1), .VS_OUT_POL(1'b0)
  ) dut_t (
    .clk(clk), .reset(reset), .dither_en(dither_en),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_window(in_window),
    .out_red(t_red), .out_green(t_green), .out_blue(t_blue),
    .out_hsync(t_hsync), .out_vsync(t_vsync), .out_de(t_de)
  );

  // ---------------- scoreboard
  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected word: {tchk, t_colour, colour x3, out_hsync, out_vsync, out_de}.
  // Inputs are active-low; out_hsync is active-high, out_vsync active-low.
  function automatic logic [15:0] mk(input logic [2:0] c, input logic hs, input logic vs,
                                     input logic win, input logic tchk, input logic [2:0] tc);
    return {tchk, tc, c, c, c, ~hs, vs, win};
  endfunction

  localparam logic [11:0] RST_WORD = {9'd0, 1'b0, 1'b1, 1'b0};

  task automatic check_reset_outputs(input string tag);
    check_eq(tag, {out_red, out_green, out_blue, out_hsync, out_vsync, out_de}, RST_WORD);
    check_eq({tag, "_t"}, {t_red, t_green, t_blue, t_hsync, t_vsync, t_de}, RST_WORD);
  endtask

  // ---------------- driver tasks (called on a falling edge)
  task automatic pix(input logic [7:0] r, input logic hs, input logic vs, input logic win,
                     input logic en, input logic [15:0] e);
    logic [15:0] f;
    if (exp_q.size() >= 2) begin
      f = exp_q.pop_front();
      check_eq(phase, {out_red, out_green, out_blue, out_hsync, out_vsync, out_de}, f[11:0]);
      if (f[15])
        check_eq({phase, "_t"}, {t_red, t_green, t_blue, t_hsync, t_vsync, t_de},
                 {f[14:12], f[14:12], f[14:12], f[2:0]});
      else
        check_eq({phase, "_tsync"}, {t_hsync, t_vsync, t_de}, f[2:0]);
    end
    in_red    = r;
    in_green  = r;
    in_blue   = r;
    in_hsync  = hs;
    in_vsync  = vs;
    in_window = win;
    dither_en = en;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // After reset release the first two outputs are still the reset values.
  task automatic prime_after_reset();
    exp_q.delete();
    exp_q.push_back(mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0));
    exp_q.push_back(mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0));
    f_cnt = 2'd0;
  endtask

  // One 4x4 frame: coincident vsync+hsync pulse, four rows of four pixels
  // separated by hsync pulses, and a trailing hsync pulse that wraps y to 0
  // so a missed "vsync wins" would start the next frame on row 1.
  // en_m: dither_en per pixel; expected colour = exp_m[i] ? hi : lo.
  // tchk: also check dut_t colour (only meaningful for 0x10 fully dithered).
  task automatic frame(input logic [7:0] r, input logic [15:0] en_m, input logic [15:0] exp_m,
                       input logic [2:0] hi, input logic [2:0] lo, input logic tchk);
    logic [1:0] xi, yi;
    logic [2:0] tv;
    f_cnt = f_cnt + 2'd1;
    pix(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
    for (int y = 0; y < 4; y++) begin
      if (y > 0) pix(8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, mk(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0));
      for (int x = 0; x < 4; x++) begin
        xi = 2'(x) + f_cnt;
        yi = 2'(y) + {1'b0, f_cnt[1]};
        tv = {2'b00, PAT[{yi, xi}]};
        pix(r, 1'b1, 1'b1, 1'b1, en_m[y*4+x],
            mk(exp_m[y*4+x] ? hi : lo, 1'b1, 1'b1, 1'b1, tchk, tv));
      end
    end
    pix(8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, mk(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0));
  endtask

  // ---------------- stimulus
  initial begin
    reset     = 1'b1;
    dither_en = 1'b0;
    in_red    = 8'h00;
    in_green  = 8'h00;
    in_blue   = 8'h00;
    in_hsync  = 1'b1;
    in_vsync  = 1'b1;
    in_window = 1'b0;
    repeat (3) @(negedge clk);

    phase = "reset";
    check_reset_outputs("reset");
    reset = 1'b0;
    prime_after_reset();

    // Truncation (dither off): 0xE5 -> 7, 2 clk later, syncs aligned.
    phase = "trunc";
    pix(8'hE5, 1'b1, 1'b1, 1'b1, 1'b0, mk(3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0));
    pix(8'h00, 1'b1, 1'b1, 1'b1, 1'b0, mk(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0));
    pix(8'h7F, 1'b0, 1'b1, 1'b1, 1'b0, mk(3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
    pix(8'h20, 1'b1, 1'b1, 1'b1, 1'b0, mk(3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0));
    pix(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, mk(3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0));

    // Blanking: full-scale input outside the window gives black.
    phase = "blank";
    pix(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0));
    pix(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0));

    phase = "ord4";
    frame(8'h10, 16'hFFFF, PAT, 3'd1, 3'd0, 1'b1);
    phase = "sat_ff";
    frame(8'hFF, 16'hFFFF, 16'h0000, 3'd0, 3'd7, 1'b0);
    phase = "zero";
    frame(8'h00, 16'hFFFF, 16'h0000, 3'd0, 3'd0, 1'b0);
    phase = "en_off";
    frame(8'h10, 16'h0000, 16'h0000, 3'd1, 3'd0, 1'b0);
    phase = "en_toggle";
    frame(8'h10, 16'h00FF, PAT & 16'h00FF, 3'd1, 3'd0, 1'b0);

    // Asynchronous reset in the middle of active video.
    phase = "midrst";
    pix(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, mk(3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0));
    pix(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, mk(3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0));
    pix(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, mk(3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0));
    check_eq("pre_rst_de", {15'd0, out_de}, 16'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst_hold");
    reset = 1'b0;
    prime_after_reset();

    // Frame-rotated dither: frame counter runs 1,2,3,0,1 after reset.
    phase = "temporal";
    for (int k = 0; k < 5; k++) frame(8'h10, 16'hFFFF, PAT, 3'd1, 3'd0, 1'b1);

    phase = "drain";
    pix(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0));
    pix(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
